// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Sequential wide adder. It adds two 4*NIBBLES-bit operands one nibble per
// clock through a single 4-bit ripple-carry adder. Operand nibbles are taken
// from the bottom of two right-shifting operand registers. The carry between
// nibbles is kept in a register. Sum nibbles are shifted into the top of an
// accumulator. This makes latency proportional to width, while the adder
// hardware stays 4 bits wide whatever NIBBLES is.
//
// Ports (nibble_serial_adder):
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous, active-high reset (highest priority)
//   start    in   1  request; accepted only on an edge where ready = 1
//   ready    out  1  idle and able to accept start
//   a_in     in   W  operand A, sampled on the accepting edge (W = 4*NIBBLES)
//   b_in     in   W  operand B, sampled on the accepting edge
//   cin      in   1  initial carry-in, sampled on the accepting edge
//   busy     out  1  addition in progress
//   sum_out  out  W  registered sum of the last completed addition
//   cout     out  1  registered carry-out of the last completed addition
//   done     out  1  one-cycle pulse marking a new sum_out/cout
//
// Ports (ripple_carry_adder_4bit):
//   A, B     in   4  addend nibbles
//   Cin      in   1  carry-in
//   Sum      out  4  sum nibble
//   Cout     out  1  carry-out
// -----------------------------------------------------------------------------

module ripple_carry_adder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] carry;

  // The carry chain is built in one process. Each stage reads the carry
  // written by the previous iteration, so the loop order forms the ripple.
  always_comb begin
    carry[0] = Cin;
    Sum      = '0;
    for (int i = 0; i < 4; i++) begin
      Sum[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout = carry[4];

endmodule


module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   ready,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  input  logic                   cin,
  output logic                   busy,
  output logic [4*NIBBLES-1:0]   sum_out,
  output logic                   cout,
  output logic                   done
);

  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,   state_d;
  logic [W-1:0]     a_q,       a_d;
  logic [W-1:0]     b_q,       b_d;
  logic [W-1:0]     acc_q,     acc_d;
  logic             carry_q,   carry_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [W-1:0]     sum_out_q, sum_out_d;
  logic             cout_q,    cout_d;

  // ---------------------------------------------------------------------------
  // Datapath: the single 4-bit adder works on the lowest operand nibbles.
  // ---------------------------------------------------------------------------
  logic [3:0]   rca_sum;
  logic         rca_cout;
  logic [W-1:0] acc_shift;

  ripple_carry_adder_4bit u_rca (
    .A    (a_q[3:0]),
    .B    (b_q[3:0]),
    .Cin  (carry_q),
    .Sum  (rca_sum),
    .Cout (rca_cout)
  );

  // New sum nibbles enter at the top. After NIBBLES shifts the first nibble
  // computed, which is the least significant, has reached bit 0.
  if (NIBBLES == 1) begin : g_acc_single
    assign acc_shift = rca_sum;
  end else begin : g_acc_multi
    assign acc_shift = {rca_sum, acc_q[W-1:4]};
  end

  // The bottom accumulator nibble is always shifted out before it could be
  // read, because the completion value is taken from acc_shift.
  logic unused_acc_low;
  assign unused_acc_low = ^acc_q[3:0];

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets its hold value first. Without this, a branch
    // that skips an assignment would infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_out_d = sum_out_q;
    cout_d    = cout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        acc_d   = acc_shift;
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = rca_cout;
        cnt_d   = cnt_q + 1'b1;
        // The last nibble is being added on this edge. Publish the assembled
        // word directly, because acc_q only catches up one edge later.
        if (cnt_q == LAST_CNT) begin
          sum_out_d = acc_shift;
          cout_d    = rca_cout;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers: synchronous reset clears all of them and aborts any operation.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample values from before the edge, whatever the statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_out_q <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sum_out_q <= sum_out_d;
      cout_q    <= cout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, with no path from start.
  // ---------------------------------------------------------------------------
  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign sum_out = sum_out_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Three adders are instantiated, with NIBBLES = 4, 1 and 8. Stimulus pushes
// the exact (W+1)-bit sum a+b+cin into a per-instance queue. A negedge monitor
// pops the queue whenever a done pulse appears, and checks the result and the
// latency from acceptance. Between pulses the monitor checks that sum_out and
// cout hold their last values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_nibble_serial_adder;

  localparam int NI = 3;   // instance 0: NIBBLES=4, 1: NIBBLES=1, 2: NIBBLES=8

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NI-1:0] start_v = '0;
  logic [NI-1:0] cin_v   = '0;
  logic [15:0]   a4 = '0, b4 = '0;
  logic [3:0]    a1 = '0, b1 = '0;
  logic [31:0]   a8 = '0, b8 = '0;

  wire [NI-1:0] ready_v, busy_v, done_v, cout_v;
  wire [15:0]   sum4;
  wire [3:0]    sum1;
  wire [31:0]   sum8;
  wire [31:0]   sum_v [NI];

  assign sum_v[0] = {16'b0, sum4};
  assign sum_v[1] = {28'b0, sum1};
  assign sum_v[2] = sum8;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .ready(ready_v[0]),
    .a_in(a4), .b_in(b4), .cin(cin_v[0]), .busy(busy_v[0]),
    .sum_out(sum4), .cout(cout_v[0]), .done(done_v[0])
  );

  nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .ready(ready_v[1]),
    .a_in(a1), .b_in(b1), .cin(cin_v[1]), .busy(busy_v[1]),
    .sum_out(sum1), .cout(cout_v[1]), .done(done_v[1])
  );

  nibble_serial_adder #(.NIBBLES(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .ready(ready_v[2]),
    .a_in(a8), .b_in(b8), .cin(cin_v[2]), .busy(busy_v[2]),
    .sum_out(sum8), .cout(cout_v[2]), .done(done_v[2])
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  logic [63:0] exp_q  [NI][$];
  int          acc_q  [NI][$];
  logic [63:0] hold_v [NI];
  logic [NI-1:0] prev_done = '0;
  int          done_cnt [NI];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int nib_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference model: exact (W+1)-bit sum of the W-bit operands and carry-in.
  function automatic logic [63:0] ref_sum(input int i, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
    int          w;
    logic [63:0] mask;
    w    = 4 * nib_of(i);
    mask = (64'd1 << w) - 64'd1;
    return ({32'b0, a} & mask) + ({32'b0, b} & mask) + {63'b0, c};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    int          w;
    int          lat;
    logic [63:0] act;
    logic [63:0] expv;
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        w   = 4 * nib_of(i);
        act = {32'b0, sum_v[i]} | ({63'b0, cout_v[i]} << w);
        if (done_v[i]) begin
          done_cnt[i]++;
          check($sformatf("done_single_cycle[%0d]", i), {63'b0, prev_done[i]}, 64'd0);
          check($sformatf("done_expected[%0d]", i), {63'b0, exp_q[i].size() > 0}, 64'd1);
          if (exp_q[i].size() > 0) begin
            expv = exp_q[i].pop_front();
            check($sformatf("result[%0d]", i), act, expv);
            hold_v[i] = expv;
          end
          check($sformatf("accept_seen[%0d]", i), {63'b0, acc_q[i].size() > 0}, 64'd1);
          if (acc_q[i].size() > 0) begin
            lat = cyc - acc_q[i].pop_front();
            check($sformatf("latency[%0d]", i), 64'(lat), 64'(nib_of(i) + 1));
          end
        end else begin
          check($sformatf("result_hold[%0d]", i), act, hold_v[i]);
        end
        if (rst) begin
          acc_q[i].delete();
          hold_v[i] = '0;
        end else if (ready_v[i] && start_v[i]) begin
          acc_q[i].push_back(cyc);
        end
        prev_done[i] = done_v[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all drive #1 after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    case (i)
      0:       begin a4 = a[15:0]; b4 = b[15:0]; end
      1:       begin a1 = a[3:0];  b1 = b[3:0];  end
      default: begin a8 = a;       b8 = b;       end
    endcase
    cin_v[i] = c;
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (!ready_v[i] && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("ready_wait[%0d]", i), {63'b0, ready_v[i]}, 64'd1);
  endtask

  task automatic wait_done(input int i, output int t);
    int n;
    n = 0;
    while (!done_v[i] && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("done_wait[%0d]", i), {63'b0, done_v[i]}, 64'd1);
    t = cyc;
  endtask

  // Issues one request. Returns in cycle 1, just after the accepting edge.
  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input bit push);
    wait_ready(i);
    set_in(i, a, b, c);
    start_v[i] = 1'b1;
    if (push) exp_q[i].push_back(ref_sum(i, a, b, c));
    tick();
    start_v[i] = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t1, t2, d0;
    foreach (hold_v[i])   hold_v[i]   = '0;
    foreach (done_cnt[i]) done_cnt[i] = 0;

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_ready[%0d]", i), {63'b0, ready_v[i]}, 64'd1);
      check($sformatf("rst_busy[%0d]", i),  {63'b0, busy_v[i]},  64'd0);
      check($sformatf("rst_done[%0d]", i),  {63'b0, done_v[i]},  64'd0);
      check($sformatf("rst_sum[%0d]", i),   {32'b0, sum_v[i]},   64'd0);
      check($sformatf("rst_cout[%0d]", i),  {63'b0, cout_v[i]},  64'd0);
    end
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // 0x1234 + 0x4321: control timing cycle by cycle after acceptance.
    do_op(0, 32'h1234, 32'h4321, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("t1_busy_c%0d", k),  {63'b0, busy_v[0]},  {63'b0, (k <= 4)});
      check($sformatf("t1_done_c%0d", k),  {63'b0, done_v[0]},  {63'b0, (k == 5)});
      check($sformatf("t1_ready_c%0d", k), {63'b0, ready_v[0]}, {63'b0, (k >= 6)});
      tick();
    end

    // Carry ripples through every nibble.
    do_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b1);
    wait_done(0, t1);

    // Back-to-back operation with start held high.
    do_op(0, 32'hFFFF, 32'hFFFF, 1'b1, 1'b1);
    set_in(0, 32'h0, 32'h0, 1'b0);
    start_v[0] = 1'b1;
    exp_q[0].push_back(ref_sum(0, 32'h0, 32'h0, 1'b0));
    wait_done(0, t1);
    tick();
    check("t3_ready_after_done", {63'b0, ready_v[0]}, 64'd1);
    tick();
    start_v[0] = 1'b0;
    wait_done(0, t2);
    check("t3_done_spacing", 64'(t2 - t1), 64'd6);

    // A start during RUN is ignored.
    do_op(0, 32'h1234, 32'h4321, 1'b0, 1'b1);
    d0 = done_cnt[0];
    tick();
    set_in(0, 32'h0001, 32'h0001, 1'b0);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    wait_done(0, t1);
    repeat (8) tick();
    check("t4_single_done", 64'(done_cnt[0] - d0), 64'd1);

    // Reset in the third RUN cycle aborts the operation without a done pulse.
    do_op(0, 32'h1111, 32'h2222, 1'b0, 1'b0);
    tick();
    tick();
    d0 = done_cnt[0];
    rst = 1'b1;
    tick();
    check("t5_ready", {63'b0, ready_v[0]}, 64'd1);
    check("t5_busy",  {63'b0, busy_v[0]},  64'd0);
    check("t5_done",  {63'b0, done_v[0]},  64'd0);
    check("t5_sum",   {32'b0, sum_v[0]},   64'd0);
    check("t5_cout",  {63'b0, cout_v[0]},  64'd0);
    rst = 1'b0;
    repeat (8) tick();
    check("t5_no_done", 64'(done_cnt[0] - d0), 64'd0);
    do_op(0, 32'h00FF, 32'h0001, 1'b0, 1'b1);
    wait_done(0, t1);
    check("t5_fresh_sum", {32'b0, sum_v[0]}, 64'h0100);

    // Reset in the DONE cycle clears done and the result on the next edge.
    do_op(0, 32'h0F0F, 32'h0101, 1'b0, 1'b1);
    wait_done(0, t1);
    rst = 1'b1;
    tick();
    check("t6_done",  {63'b0, done_v[0]},  64'd0);
    check("t6_sum",   {32'b0, sum_v[0]},   64'd0);
    check("t6_cout",  {63'b0, cout_v[0]},  64'd0);
    check("t6_ready", {63'b0, ready_v[0]}, 64'd1);
    rst = 1'b0;
    tick();

    // Random operands on the NIBBLES=1 and NIBBLES=8 instances in parallel.
    fork
      begin
        for (int n = 0; n < 1000; n++)
          do_op(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      end
      begin
        for (int n = 0; n < 1000; n++)
          do_op(2, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      end
    join
    repeat (20) tick();

    for (int i = 0; i < NI; i++)
      check($sformatf("scoreboard_drained[%0d]", i), 64'(exp_q[i].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
